// File: rtl/scan_io_memory_bank_pkg.sv
// Shared definitions for the scan-chained I/O memory bank.
//   LEVEL_LSB  : bit position of the synchronised button levels in the status word
//   flag_lsb() : bit position of the sticky rising-edge flags in the status word
//   chain_len(): total scan chain length in bits (words * word width)
package scan_io_pkg;

   localparam int LEVEL_LSB = 0;

   function automatic int flag_lsb(input int btn_width);
      return btn_width;
   endfunction

   function automatic int chain_len(input int mem_size, input int data_width);
      return mem_size * data_width;
   endfunction

endpackage

// File: rtl/scan_io_memory_bank_if.sv
// CPU-side bus of the memory bank.
//   address      : word address (master -> slave)
//   data_in      : write data (master -> slave)
//   write_enable : write strobe (master -> slave)
//   data_out     : combinational read data (slave -> master)
interface scan_io_memory_bank_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] address;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  write_enable;
   logic [DATA_WIDTH-1:0] data_out;

   modport master (output address, output data_in, output write_enable, input data_out);
   modport slave  (input address, input data_in, input write_enable, output data_out);
endinterface

// File: rtl/scan_io_memory_bank_btn.sv
// Multi-flop synchroniser with rising-edge detect for one asynchronous input.
//   clk      : system clock
//   rst      : synchronous reset, active low
//   async_in : asynchronous pin
//   level    : synchronised level (last synchroniser stage)
//   rise     : high for the cycle in which level first reads 1
module btn_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic level,
   output logic rise
);
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign level = r_sync[SYNC_STAGES-1];
   assign rise  = level & ~r_prev;
endmodule

// File: rtl/scan_io_memory_bank.sv
// Scan-chained memory bank with LED output word and button status word.
//   clk, rst          : system clock, synchronous active-low reset
//   bus               : CPU bus (address, data_in, write_enable, data_out)
//   scan_enable       : shift the whole chain one bit per edge
//   scan_in, scan_out : chain serial in/out (out = MSB of the last word)
//   scan_done         : one-cycle pulse after a full chain length was shifted
//   btn_in            : asynchronous buttons; read back at IO_IN_ADDR
//   led_out           : low bits of word IO_OUT_ADDR
module scan_io_memory_bank
   import scan_io_pkg::*;
#(
   parameter int ADDR_WIDTH  = 5,
   parameter int DATA_WIDTH  = 8,
   parameter int MEM_SIZE    = 32,
   parameter int IO_OUT_ADDR = 15,
   parameter int IO_IN_ADDR  = 14,
   parameter int BTN_WIDTH   = 2,
   parameter int LED_WIDTH   = 7,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   scan_io_memory_bank_if.slave bus,
   input  logic                 scan_enable,
   input  logic                 scan_in,
   output logic                 scan_out,
   output logic                 scan_done,
   input  logic [BTN_WIDTH-1:0] btn_in,
   output logic [LED_WIDTH-1:0] led_out
);
   localparam int LP_CHAIN   = chain_len(MEM_SIZE, DATA_WIDTH);
   localparam int LP_CNT_W   = $clog2(LP_CHAIN);
   localparam int LP_IDX_W   = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
   localparam int LP_FLAG_LSB = flag_lsb(BTN_WIDTH);
   localparam logic [ADDR_WIDTH:0]   LP_MEM_SIZE = (ADDR_WIDTH+1)'(MEM_SIZE);
   localparam logic [ADDR_WIDTH-1:0] LP_IN_ADDR  = ADDR_WIDTH'(IO_IN_ADDR);
   localparam logic [LP_CNT_W-1:0]   LP_CNT_LAST = LP_CNT_W'(LP_CHAIN - 1);

   logic [DATA_WIDTH-1:0] r_mem [MEM_SIZE];
   logic [BTN_WIDTH-1:0]  r_flag;
   logic [LP_CNT_W-1:0]   r_scan_cnt;
   logic                  r_scan_done;

   logic [BTN_WIDTH-1:0]  w_level;
   logic [BTN_WIDTH-1:0]  w_rise;
   logic                  w_in_range;
   logic                  w_is_io_in;
   logic                  w_wr_mem;
   logic                  w_wr_clr;
   logic [LP_IDX_W-1:0]   w_idx;
   logic [DATA_WIDTH-1:0] w_io_word;

   for (genvar g = 0; g < BTN_WIDTH; g++) begin : g_btn
      btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_btn (
         .clk      (clk),
         .rst      (rst),
         .async_in (btn_in[g]),
         .level    (w_level[g]),
         .rise     (w_rise[g])
      );
   end

   assign w_in_range = {1'b0, bus.address} < LP_MEM_SIZE;
   assign w_is_io_in = bus.address == LP_IN_ADDR;
   assign w_idx      = bus.address[LP_IDX_W-1:0];
   assign w_wr_mem   = bus.write_enable && !scan_enable && w_in_range && !w_is_io_in;
   assign w_wr_clr   = bus.write_enable && !scan_enable && w_is_io_in;

   // Storage: the chain shift takes precedence over bus writes.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < MEM_SIZE; i++) r_mem[i] <= '0;
      end else if (scan_enable) begin
         r_mem[0] <= {r_mem[0][DATA_WIDTH-2:0], scan_in};
         for (int i = 1; i < MEM_SIZE; i++)
            r_mem[i] <= {r_mem[i][DATA_WIDTH-2:0], r_mem[i-1][DATA_WIDTH-1]};
      end else if (w_wr_mem) begin
         r_mem[w_idx] <= bus.data_in;
      end
   end

   // Sticky flags: a new rising edge beats a same-cycle write-1-to-clear.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_flag <= '0;
      end else begin
         for (int i = 0; i < BTN_WIDTH; i++) begin
            if (w_rise[i])
               r_flag[i] <= 1'b1;
            else if (w_wr_clr && bus.data_in[LP_FLAG_LSB + i])
               r_flag[i] <= 1'b0;
         end
      end
   end

   // Chain-length tracking; any gap in scan_enable discards the partial count.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_scan_cnt  <= '0;
         r_scan_done <= 1'b0;
      end else begin
         r_scan_done <= 1'b0;
         if (!scan_enable) begin
            r_scan_cnt <= '0;
         end else if (r_scan_cnt == LP_CNT_LAST) begin
            r_scan_cnt  <= '0;
            r_scan_done <= 1'b1;
         end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      w_io_word = '0;
      w_io_word[LEVEL_LSB +: BTN_WIDTH]   = w_level;
      w_io_word[LP_FLAG_LSB +: BTN_WIDTH] = r_flag;
   end

   always_comb begin
      bus.data_out = '0;
      if (w_is_io_in)
         bus.data_out = w_io_word;
      else if (w_in_range)
         bus.data_out = r_mem[w_idx];
   end

   assign led_out   = r_mem[IO_OUT_ADDR][LED_WIDTH-1:0];
   assign scan_out  = r_mem[MEM_SIZE-1][DATA_WIDTH-1];
   assign scan_done = r_scan_done;
endmodule

// File: doc/scan_io_memory_bank.md
Name: scan_io_memory_bank

Overview:
- Parametrised successor to the 32x8 scan-chained memory bank.
- Generalises depth, width and I/O widths; adds bounds-checked access, a synchronised button input word with sticky edge flags, and scan-length tracking with a completion pulse.
- Sits between the CPU core bus (address/data/write_enable) and the board I/O pins.
- Shares the global scan chain with the other programmable blocks.

Parameters:
- ADDR_WIDTH, 5, bus address width.
- DATA_WIDTH, 8, word width; must be >= 2*BTN_WIDTH and >= LED_WIDTH.
- MEM_SIZE, 32, number of storage words; <= 2**ADDR_WIDTH.
- IO_OUT_ADDR, 15, word whose low LED_WIDTH bits drive led_out.
- IO_IN_ADDR, 14, address that reads the button status word instead of storage.
- BTN_WIDTH, 2, button input count.
- LED_WIDTH, 7, LED output count.
- SYNC_STAGES, 2, synchroniser flop depth (>= 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset, sampled on rising clk).
- address  in  ADDR_WIDTH  word address.
- data_in  in  DATA_WIDTH  write data.
- write_enable  in  1  write strobe.
- data_out  out  DATA_WIDTH  combinational read data.
- scan_enable  in  1  shift whole chain one bit.
- scan_in  in  1  chain serial input.
- scan_out  out  1  chain serial output.
- scan_done  out  1  one-cycle pulse after a full chain length has been shifted.
- btn_in  in  BTN_WIDTH  asynchronous button pins.
- led_out  out  LED_WIDTH  LED drive.

Behaviour:
- Reset (rst=0 at an edge): all storage words, synchroniser flops, edge-history register, sticky flags and scan bit counter go to 0; scan_done=0. Consequently led_out=0 and scan_out=0.
- Priority at each edge: reset > scan shift > bus write.
- Bus write:
  - Condition: write_enable=1, scan_enable=0, address<MEM_SIZE, address!=IO_IN_ADDR.
  - Effect: word[address] <= data_in; visible on data_out and led_out one edge later.
  - Out-of-range writes (address>=MEM_SIZE) are silently ignored.
- Write to IO_IN_ADDR (scan_enable=0): write-1-to-clear of sticky flags. data_in[BTN_WIDTH+i]=1 clears flag i. A set in the same cycle wins over the clear. The backing word at IO_IN_ADDR is not written.
- Read is combinational:
  - address==IO_IN_ADDR: data_out = {zeros, flags[BTN_WIDTH-1:0], level[BTN_WIDTH-1:0]}.
  - address<MEM_SIZE otherwise: data_out = word[address].
  - address>=MEM_SIZE: data_out = 0.
- led_out = word[IO_OUT_ADDR][LED_WIDTH-1:0], continuously.
- Scan chain (scan_enable=1), per edge:
  - Each word shifts left one bit.
  - word[0] bit0 <= scan_in; word[i] bit0 <= word[i-1] MSB.
  - scan_out = word[MEM_SIZE-1] MSB, combinational.
  - The backing word at IO_IN_ADDR participates in the chain. Flags and synchronisers are not in the chain.
  - Bus writes and flag clears are suppressed during a shift.
- Scan counter, width clog2(MEM_SIZE*DATA_WIDTH):
  - Clears whenever scan_enable=0.
  - Increments on each shift edge.
  - On the shift edge where the count equals MEM_SIZE*DATA_WIDTH-1: count wraps to 0, and scan_done=1 for exactly the following cycle.
  - Dropping scan_enable mid-chain discards the partial count with no pulse; chain contents are retained.
- Button path, per bit:
  - SYNC_STAGES-flop synchroniser; level = last stage.
  - prev <= level every edge; a rising edge is level & ~prev.
  - The flag sets on a rising edge and holds until cleared or reset.
  - level is visible SYNC_STAGES edges after btn_in changes; the flag one edge after that.
  - A pulse shorter than one clock period may be missed; this is acceptable.
- Reset asserted mid-scan or mid-write: the reset result takes effect at that edge; the operation is not completed.

Decomposition:
- Shared package scan_io_pkg:
  - Flag/level bit-offset constants for the IO_IN word.
  - The chain-length constant function MEM_SIZE*DATA_WIDTH.
- One sub-module, btn_sync_edge (params SYNC_STAGES; ports clk, rst, async_in, level, rise):
  - One instance per button bit.
  - Also reusable for other board inputs.
- Storage words and scan counter are inline in the top.

Test Plan:
- Reset, then write 0x5A at address 15, then 0x33 at address 3 -> next cycle led_out=0x5A; reads of 15 and 3 return 0x5A and 0x33; address 31 reads 0x00.
- MEM_SIZE=24: write 0xFF to address 28 -> no word changes; read of 28 returns 0x00.
- btn_in=2'b01 held from cycle 0 -> level bit0=1 at cycle 2 and flag bit2=1 at cycle 3 (read IO_IN_ADDR = 0x05). Release btn_in, then write 0x04 to IO_IN_ADDR -> read returns 0x00.
- Flag clear coinciding with a new rising edge on bit1 -> flag bit3 remains 1.
- Shift 256 bits of pattern 0xA5 per byte with scan_enable=1 -> scan_done pulses exactly once, on the cycle after the 256th shift; every word reads 0xA5; scan_out sequence replays the prior memory contents MSB-first from word 31.
- Assert rst=0 after 100 shifts, release, shift 256 more -> all words 0 before the new shifts; scan_done pulses only after 256 post-reset shifts.
